// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : Fetch/retire sequencer for a core with one shared memory
//               port. Instruction fetch (IFETCH) and data access (DWAIT)
//               never overlap, so iREN is only raised while fetching.
//               Produces a one-cycle pc_en pulse per retired instruction
//               and the next-PC source select.
// Optional    : `define FETCH_PERF_EN adds the instr_count / stall_count
//               performance counters; otherwise both outputs are tied to 0.
// Ports       : CLK, nRST (async, active-low)
//               ihit, dhit          - memory handshakes
//               dREN, dWEN          - decoded data read / write request
//               Branch, Jump, JR    - decoded redirect requests
//               halt                - decoded halt
//               pc_en, pc_sel[1:0]  - PC load enable / source select
//               iREN, halted        - fetch request / core stopped
//               fstate[1:0]         - 00 IDLE, 01 IFETCH, 10 DWAIT, 11 HALT
//               instr_count, stall_count [31:0] - performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller #(
    parameter int IDLE_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        JR,
    input  logic        halt,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        iREN,
    output logic        halted,
    output logic [1:0]  fstate,
    output logic [31:0] instr_count,
    output logic [31:0] stall_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_IFETCH = 2'b01,
        S_DWAIT  = 2'b10,
        S_HALT   = 2'b11
    } state_t;

    localparam logic [3:0] c_IDLE_LAST = 4'(IDLE_CYCLES - 1);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_idle_cnt;
    logic [3:0] w_next_idle_cnt;
    logic [1:0] r_sel_q;
    logic [1:0] w_next_sel_q;
    logic [1:0] w_redirect;

    // Redirect priority: JR > Jump > Branch > sequential.
    assign w_redirect = JR     ? 2'b11 :
                        Jump   ? 2'b10 :
                        Branch ? 2'b01 : 2'b00;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state    <= S_IDLE;
            r_idle_cnt <= 4'd0;
            r_sel_q    <= 2'b00;
        end else begin
            r_state    <= w_next_state;
            r_idle_cnt <= w_next_idle_cnt;
            r_sel_q    <= w_next_sel_q;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_idle_cnt = r_idle_cnt;
        w_next_sel_q    = r_sel_q;
        pc_en           = 1'b0;
        pc_sel          = 2'b00;
        iREN            = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_idle_cnt == c_IDLE_LAST) begin
                    w_next_state    = S_IFETCH;
                    w_next_idle_cnt = 4'd0;
                end else begin
                    w_next_idle_cnt = r_idle_cnt + 4'd1;
                end
            end
            S_IFETCH: begin
                iREN   = 1'b1;
                pc_sel = w_redirect;
                if (ihit) begin
                    if (halt) begin
                        w_next_state = S_HALT;
                    end else if (dREN || dWEN) begin
                        // Retirement deferred to dhit; keep the redirect
                        // because decode inputs may change while waiting.
                        w_next_state = S_DWAIT;
                        w_next_sel_q = w_redirect;
                    end else begin
                        pc_en = 1'b1;
                    end
                end
            end
            S_DWAIT: begin
                pc_sel = r_sel_q;
                if (dhit) begin
                    pc_en        = 1'b1;
                    w_next_state = S_IFETCH;
                end
            end
            S_HALT: begin
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign halted = (r_state == S_HALT);
    assign fstate = r_state;

`ifdef FETCH_PERF_EN
    logic [31:0] r_instr_count;
    logic [31:0] r_stall_count;
    logic        w_stall;

    // A stall is any fetch/data-wait cycle that does not retire.
    assign w_stall = ((r_state == S_IFETCH) || (r_state == S_DWAIT)) && !pc_en;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_instr_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (pc_en) begin
                r_instr_count <= r_instr_count + 32'd1;
            end
            if (w_stall) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end

    assign instr_count = r_instr_count;
    assign stall_count = r_stall_count;
`else
    assign instr_count = 32'd0;
    assign stall_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_controller
// Description : Self-checking bench for fetch_controller. Random instruction
//               scripts (fetch wait, redirects, optional data op and its
//               latency) are turned into expected per-cycle outputs and
//               expected counter totals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_controller;

    localparam int IDLE = 3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, dREN, dWEN, Branch, Jump, JR, halt;
    logic        pc_en, iREN, halted;
    logic [1:0]  pc_sel, fstate;
    logic [31:0] instr_count, stall_count;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_instr = 32'd0;
    logic [31:0] exp_stall = 32'd0;

    fetch_controller #(.IDLE_CYCLES(IDLE)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dREN(dREN),
        .dWEN(dWEN), .Branch(Branch), .Jump(Jump), .JR(JR), .halt(halt),
        .pc_en(pc_en), .pc_sel(pc_sel), .iREN(iREN), .halted(halted),
        .fstate(fstate), .instr_count(instr_count), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        ihit = 0; dhit = 0; dREN = 0; dWEN = 0;
        Branch = 0; Jump = 0; JR = 0; halt = 0;
    endtask

    // Advance one clock; expected counters follow the retire/stall rules.
    task automatic adv(input logic pe, input logic active);
        @(posedge CLK);
`ifdef FETCH_PERF_EN
        if (pe) exp_instr = exp_instr + 32'd1;
        if (active && !pe) exp_stall = exp_stall + 32'd1;
`endif
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST = 0;
        @(negedge CLK);
        checks++;
        if ({pc_en, iREN, pc_sel, fstate, halted, instr_count, stall_count} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got pc_en=%b iREN=%b sel=%b fstate=%b halted=%b ic=%0d sc=%0d, want all 0",
                     pc_en, iREN, pc_sel, fstate, halted, instr_count, stall_count);
        end
        @(posedge CLK); #1;
        nRST = 1;
        ihit = 1;
        for (int i = 0; i < IDLE; i++) begin
            @(negedge CLK);
            checks++;
            if ({fstate, iREN, pc_en} !== 4'b0000) begin
                failures++;
                $display("FAIL idle_cycle%0d: got fstate=%b iREN=%b pc_en=%b, want 00 0 0", i, fstate, iREN, pc_en);
            end
            adv(1'b0, 1'b0);
        end
    endtask

    task automatic test_stream();
        ihit = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if ({fstate, iREN, pc_en, pc_sel} !== 6'b01_1_1_00) begin
                failures++;
                $display("FAIL stream_cycle%0d: got fstate=%b iREN=%b pc_en=%b sel=%b, want 01 1 1 00",
                         i, fstate, iREN, pc_en, pc_sel);
            end
            adv(1'b1, 1'b1);
        end
        checks++;
        if (instr_count !== exp_instr || stall_count !== exp_stall) begin
            failures++;
            $display("FAIL stream_counters: got ic=%0d sc=%0d, want ic=%0d sc=%0d",
                     instr_count, stall_count, exp_instr, exp_stall);
        end
    endtask

    // One instruction: fetch wait cycles, then ihit with given decode,
    // then optional data wait of dlat cycles before dhit.
    task automatic run_instr(input int w, input logic b, input logic j, input logic jr,
                             input logic dr, input logic dw, input int dlat, input string nm);
        logic [1:0] sel;
        sel = jr ? 2'd3 : (j ? 2'd2 : (b ? 2'd1 : 2'd0));
        for (int i = 0; i < w; i++) begin
            clear_inputs();
            dhit = 1'($urandom); dREN = 1'($urandom); halt = 1'($urandom);
            @(negedge CLK);
            checks++;
            if ({fstate, iREN, pc_en} !== 4'b01_1_0) begin
                failures++;
                $display("FAIL %s_fetchwait: got fstate=%b iREN=%b pc_en=%b, want 01 1 0", nm, fstate, iREN, pc_en);
            end
            adv(1'b0, 1'b1);
        end
        clear_inputs();
        ihit = 1; Branch = b; Jump = j; JR = jr; dREN = dr; dWEN = dw;
        @(negedge CLK);
        checks++;
        if ({fstate, iREN, pc_sel, pc_en} !== {2'b01, 1'b1, sel, !(dr || dw)}) begin
            failures++;
            $display("FAIL %s_ihit: got fstate=%b iREN=%b sel=%b pc_en=%b, want 01 1 %b %b",
                     nm, fstate, iREN, pc_sel, pc_en, sel, !(dr || dw));
        end
        adv(!(dr || dw), 1'b1);
        if (dr || dw) begin
            for (int i = 0; i <= dlat; i++) begin
                clear_inputs();
                ihit = 1'($urandom); Branch = 1'($urandom); Jump = 1'($urandom); JR = 1'($urandom);
                dhit = (i == dlat);
                @(negedge CLK);
                checks++;
                if ({fstate, iREN, pc_sel, pc_en} !== {2'b10, 1'b0, sel, dhit}) begin
                    failures++;
                    $display("FAIL %s_dwait%0d: got fstate=%b iREN=%b sel=%b pc_en=%b, want 10 0 %b %b",
                             nm, i, fstate, iREN, pc_sel, pc_en, sel, dhit);
                end
                adv(dhit, 1'b1);
            end
        end
        clear_inputs();
        checks++;
        if (instr_count !== exp_instr || stall_count !== exp_stall) begin
            failures++;
            $display("FAIL %s_counters: got ic=%0d sc=%0d, want ic=%0d sc=%0d",
                     nm, instr_count, stall_count, exp_instr, exp_stall);
        end
    endtask

    task automatic test_directed();
        run_instr(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, "prio_all");
        run_instr(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, "prio_jump");
        run_instr(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "prio_branch");
        run_instr(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3, "dread_branch");
        run_instr(0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2, "drw_both");
        run_instr(2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, "dwrite_fast");
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++) begin
            logic dop;
            dop = ($urandom_range(0, 2) == 0);
            run_instr($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                      dop & 1'($urandom), dop, $urandom_range(0, 3), "rand");
        end
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        ihit = 1; dREN = 1; Jump = 1;
        adv(1'b0, 1'b1);
        clear_inputs();
        @(negedge CLK);
        checks++;
        if (fstate !== 2'b10) begin
            failures++;
            $display("FAIL rstmid_in_dwait: got fstate=%b, want 10", fstate);
        end
        #2;
        nRST = 0; dhit = 1; ihit = 1;
        #1;
        exp_instr = 32'd0; exp_stall = 32'd0;
        checks++;
        if ({pc_en, iREN, pc_sel, fstate, halted, instr_count, stall_count} !== '0) begin
            failures++;
            $display("FAIL rstmid_async: got pc_en=%b iREN=%b sel=%b fstate=%b halted=%b ic=%0d sc=%0d, want all 0",
                     pc_en, iREN, pc_sel, fstate, halted, instr_count, stall_count);
        end
        @(posedge CLK); #1;
        nRST = 1;
        for (int i = 0; i < IDLE; i++) begin
            @(negedge CLK);
            checks++;
            if ({fstate, pc_en, iREN} !== 4'b0000) begin
                failures++;
                $display("FAIL rstmid_idle%0d: got fstate=%b pc_en=%b iREN=%b, want 00 0 0", i, fstate, pc_en, iREN);
            end
            adv(1'b0, 1'b0);
        end
        clear_inputs();
        run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "after_rst");
    endtask

`ifdef FETCH_PERF_EN
    task automatic test_wrap();
        clear_inputs();
        force dut.r_instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_instr_count;
        exp_instr = 32'hFFFF_FFFF;
        run_instr(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "wrap");
        checks++;
        if (instr_count !== 32'd0) begin
            failures++;
            $display("FAIL wrap_zero: got ic=%h, want 00000000", instr_count);
        end
    endtask
`endif

    task automatic test_halt();
        clear_inputs();
        ihit = 1; halt = 1; Jump = 1; dREN = 1;
        @(negedge CLK);
        checks++;
        if (pc_en !== 1'b0) begin
            failures++;
            $display("FAIL halt_ihit_pcen: got %b, want 0", pc_en);
        end
        adv(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            clear_inputs();
            ihit = 1'($urandom); dhit = 1'($urandom); dREN = 1'($urandom); Branch = 1'($urandom);
            @(negedge CLK);
            checks++;
            if ({fstate, halted, pc_en, iREN, pc_sel} !== 7'b11_1_0_0_00) begin
                failures++;
                $display("FAIL halt_hold%0d: got fstate=%b halted=%b pc_en=%b iREN=%b sel=%b, want 11 1 0 0 00",
                         i, fstate, halted, pc_en, iREN, pc_sel);
            end
            adv(1'b0, 1'b0);
        end
        checks++;
        if (instr_count !== exp_instr || stall_count !== exp_stall) begin
            failures++;
            $display("FAIL halt_frozen: got ic=%0d sc=%0d, want ic=%0d sc=%0d",
                     instr_count, stall_count, exp_instr, exp_stall);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_directed();
        test_random();
        test_reset_mid();
`ifdef FETCH_PERF_EN
        test_wrap();
`endif
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter: IDLE_CYCLES, default 1, number of post-reset cycles spent in IDLE before the first fetch (range 1..15).
REQ-002 SHALL have port: CLK  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port: nRST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: ihit  input  1  instruction memory returned a valid word this cycle.
REQ-005 SHALL have port: dhit  input  1  data memory access completed this cycle.
REQ-006 SHALL have port: dREN  input  1  decoded instruction requests a data read.
REQ-007 SHALL have port: dWEN  input  1  decoded instruction requests a data write.
REQ-008 SHALL have port: Branch, Jump, JR  input  1 each  decoded redirect requests for the current instruction.
REQ-009 SHALL have port: halt  input  1  decoded halt instruction.
REQ-010 SHALL have port: pc_en  output  1  load enable for program counter, one-cycle pulse per retired instruction.
REQ-011 SHALL have port: pc_sel  output  2  next-PC source: 00 sequential, 01 branch, 10 jump, 11 jump-register.
REQ-012 SHALL have port: iREN  output  1  instruction fetch request.
REQ-013 SHALL have port: halted  output  1  core stopped.
REQ-014 SHALL have port: fstate  output  2  current state: 00 IDLE, 01 IFETCH, 10 DWAIT, 11 HALT.
REQ-015 SHALL have port: instr_count, stall_count  output  32 each  performance counters (see Configuration).

Function
REQ-016 SHALL implement FSM IDLE, IFETCH, DWAIT, HALT; single shared memory port, so iREN=1 only in IFETCH.
REQ-017 IDLE: iREN=0, pc_en=0; 4-bit counter counts IDLE_CYCLES cycles, then -> IFETCH.
REQ-018 IFETCH, halt=1 with ihit=1: -> HALT, pc_en=0; halt has priority over all other inputs.
REQ-019 IFETCH, ihit=1, dREN|dWEN=1: -> DWAIT, pc_en=0, redirect select latched into sel_q.
REQ-020 IFETCH, ihit=1, no data op: pc_en=1 same cycle (combinational), remain IFETCH.
REQ-021 IFETCH, ihit=0: pc_en=0, remain IFETCH; inputs other than nRST ignored.
REQ-022 DWAIT: iREN=0; dhit=1 -> pc_en=1, pc_sel=sel_q, -> IFETCH; dhit=0 -> hold; Branch/Jump/JR ignored in DWAIT.
REQ-023 dREN and dWEN both 1 SHALL be treated as one data op (single DWAIT, single dhit).
REQ-024 pc_sel in IFETCH SHALL be combinational priority JR > Jump > Branch > sequential; in DWAIT SHALL equal sel_q; else 00.
REQ-025 HALT: absorbing until reset; halted=1, iREN=0, pc_en=0; ihit/dhit ignored.
REQ-026 pc_en SHALL never be high for two instructions without an intervening ihit.

Reset
REQ-027 nRST low SHALL asynchronously force: state IDLE, idle counter 0, sel_q 00, halted 0, pc_en 0, iREN 0, pc_sel 00, counters 0.
REQ-028 Reset asserted mid-DWAIT or mid-IFETCH SHALL abandon the access; no pc_en pulse on the reset cycle or the release cycle.

Configuration
REQ-029 Macro FETCH_PERF_EN defined: instr_count +1 per cycle pc_en=1; stall_count +1 per IFETCH/DWAIT cycle with pc_en=0; both wrap 0xFFFFFFFF -> 0; both frozen in HALT.
REQ-030 FETCH_PERF_EN undefined: instr_count and stall_count tied to 0, no counter flops synthesized.

Verification
REQ-031 Reset release, IDLE_CYCLES=1, ihit high continuously -> fstate 00 for 1 cycle, then iREN=1 and pc_en=1 every cycle; instr_count=10 after 10 cycles (PERF on).
REQ-032 ihit with dREN=1, Branch=1; dhit after 3 cycles -> DWAIT 3 cycles, iREN=0, then pc_en=1 with pc_sel=01; stall_count=3.
REQ-033 ihit with JR=1, Jump=1, Branch=1 -> pc_sel=11, pc_en=1 same cycle.
REQ-034 ihit with halt=1, Jump=1 -> HALT next cycle, halted=1, pc_en never asserts; subsequent ihit/dhit pulses ignored.
REQ-035 nRST pulsed low during DWAIT -> all outputs 0 immediately, IDLE on release, no pc_en pulse.
REQ-036 PERF on, preload instr_count to 0xFFFFFFFF via force, one retire -> instr_count=0.
